nonrestoring_div8: RTL and testbench

- Iterative unsigned non-restoring divider; the sequential inverse-arithmetic companion to the team's CLA adder-subtractor slices.
- Uses one shared (WIDTH+1)-bit add/subtract datapath and produces one quotient bit per clock.
- Input and output use valid/ready handshakes.
- Sits beside the ALU as a multi-cycle functional unit.

---
 rtl/nonrestoring_div8.sv | 131 +++++++++++++
 tb/tb_nonrestoring_div8.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/nonrestoring_div8.sv
// Iterative unsigned non-restoring divider: one quotient bit per clock through a
// single shared (WIDTH+1)-bit adder-subtractor, valid/ready on both sides.
module nonrestoring_div8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             divByZero
);

    // state | meaning
    // IDLE  | waiting for operands
    // CALC  | one shift/add-or-subtract step per clock
    // FIX   | restore a negative final remainder
    // DONE  | result held until the consumer takes it
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic             live_q;

    logic [WIDTH:0]   add_a, add_b, add_y, r_fix;
    logic             sub;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            live_q  <= 1'b1;
        end
    end

    // Shared datapath: CALC feeds the shifted remainder, FIX feeds R and always adds.
    always_comb begin
        add_a = (state_q == CALC) ? {r_q[WIDTH-1:0], q_q[WIDTH-1]} : r_q;
        sub   = (state_q == CALC) ? ~r_q[WIDTH] : 1'b0;
        add_b = sub ? ~{1'b0, d_q} : {1'b0, d_q};
        add_y = add_a + add_b + {{WIDTH{1'b0}}, sub};
        r_fix = r_q[WIDTH] ? add_y : r_q;
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            IDLE: begin
                if (inValid && live_q) begin
                    d_d   = divisor;
                    q_d   = dividend;
                    r_d   = '0;
                    cnt_d = CNT_INIT;
                    if (divisor == '0) begin
                        quo_d   = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                r_d   = add_y;
                q_d   = {q_q[WIDTH-2:0], ~add_y[WIDTH]};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                r_d     = r_fix;
                quo_d   = q_q;
                rem_d   = r_fix[WIDTH-1:0];
                dbz_d   = 1'b0;
                state_d = DONE;
            end
            DONE: begin
                if (outReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign inReady   = live_q && (state_q == IDLE);
    assign outValid  = (state_q == DONE);
    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign divByZero = dbz_q;

endmodule

// File: tb/tb_nonrestoring_div8.sv
// Randomized and directed checks of nonrestoring_div8 against plain / and % arithmetic.
module tb_nonrestoring_div8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       inValid, inReady, outValid, outReady, divByZero;
    logic [7:0] dividend, divisor, quotient, remainder;

    int n_cmp = 0;
    int n_bad = 0;

    nonrestoring_div8 #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .inValid(inValid), .inReady(inReady),
        .dividend(dividend), .divisor(divisor),
        .outValid(outValid), .outReady(outReady),
        .quotient(quotient), .remainder(remainder),
        .divByZero(divByZero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Called on a falling edge; returns on a falling edge with the unit back in IDLE.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int hold, input bit noise);
        logic [7:0] eq, er;
        logic       ez;
        int         cyc;
        ez = (b == 8'd0);
        eq = ez ? 8'hFF : a / b;
        er = ez ? a : a % b;
        cyc = 0;
        while (!inReady && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("in_ready_wait", {31'd0, inReady}, 32'd1);
        inValid  = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        inValid = 1'b0;
        cyc = 0;
        while (!outValid && cyc < 40) begin
            chk("busy_in_ready", {31'd0, inReady}, 32'd0);
            if (noise) begin
                inValid  = 1'($urandom);
                dividend = 8'($urandom);
                divisor  = 8'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        inValid = 1'b0;
        chk("latency", cyc, ez ? 32'd0 : 32'd9);
        for (int i = 0; i < hold; i++) begin
            chk("hold_valid", {31'd0, outValid}, 32'd1);
            chk("hold_quot", {24'd0, quotient}, {24'd0, eq});
            chk("hold_rem", {24'd0, remainder}, {24'd0, er});
            chk("hold_inready", {31'd0, inReady}, 32'd0);
            @(negedge clk);
        end
        chk("out_valid", {31'd0, outValid}, 32'd1);
        chk("quotient", {24'd0, quotient}, {24'd0, eq});
        chk("remainder", {24'd0, remainder}, {24'd0, er});
        chk("div_by_zero", {31'd0, divByZero}, {31'd0, ez});
        outReady = 1'b1;
        @(negedge clk);
        outReady = 1'b0;
        chk("valid_drop", {31'd0, outValid}, 32'd0);
        chk("ready_back", {31'd0, inReady}, 32'd1);
    endtask

    initial begin
        int cyc;
        rst_n    = 1'b0;
        inValid  = 1'b0;
        outReady = 1'b0;
        dividend = '0;
        divisor  = '0;
        #1;
        chk("rst_in_ready", {31'd0, inReady}, 32'd0);
        chk("rst_out_valid", {31'd0, outValid}, 32'd0);
        chk("rst_quot", {24'd0, quotient}, 32'd0);
        chk("rst_rem", {24'd0, remainder}, 32'd0);
        chk("rst_dbz", {31'd0, divByZero}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rel_in_ready_low", {31'd0, inReady}, 32'd0);
        @(negedge clk);
        chk("rel_in_ready_high", {31'd0, inReady}, 32'd1);

        run_op(8'd200, 8'd7, 0, 1'b0);
        run_op(8'd255, 8'd1, 0, 1'b0);
        run_op(8'd5, 8'd9, 0, 1'b0);
        run_op(8'd255, 8'd255, 0, 1'b0);
        run_op(8'd100, 8'd0, 0, 1'b0);
        run_op(8'd128, 8'd3, 3, 1'b0);
        run_op(8'd150, 8'd11, 1, 1'b1);
        run_op(8'd0, 8'd1, 0, 1'b0);
        run_op(8'd1, 8'd255, 0, 1'b0);

        // Asynchronous reset in the middle of CALC
        cyc = 0;
        while (!inReady && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        inValid  = 1'b1;
        dividend = 8'd77;
        divisor  = 8'd5;
        @(negedge clk);
        inValid = 1'b0;
        repeat (3) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, outValid}, 32'd0);
        chk("mid_rst_ready", {31'd0, inReady}, 32'd0);
        chk("mid_rst_quot", {24'd0, quotient}, 32'd0);
        chk("mid_rst_rem", {24'd0, remainder}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (outValid) cyc++;
        end
        chk("no_stale_valid", cyc, 32'd0);
        run_op(8'd64, 8'd8, 0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            logic [7:0] a, b;
            a = 8'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            run_op(a, b, $urandom_range(0, 3), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
